// File: rtl/fetch_sequencer_pkg.sv
// Shared types and helpers for the instruction fetch sequencer.
package fetch_pkg;

  // Byte distance between consecutive instruction words.
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StValid,
    StFault
  } fetch_state_e;

  // Word-address width; kept at least one bit so a single-word memory still has a port.
  function automatic int unsigned addr_width(input int unsigned words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

  // A PC is legal when its word index falls inside the instruction memory.
  function automatic logic pc_in_range(input logic [31:0] pc_val, input int unsigned words);
    return {2'b00, pc_val[31:2]} < words;
  endfunction

  // State to enter after loading a new PC: fetch it, or park in FAULT if it is illegal.
  function automatic fetch_state_e fetch_or_fault(input logic [31:0] pc_val,
                                                  input int unsigned words);
    return pc_in_range(pc_val, words) ? StReq : StFault;
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction memory read port: request/address out, ack/data back.
interface fetch_sequencer_if #(
  parameter int unsigned MEM_WORDS = 64
);
  localparam int unsigned AddrW = fetch_pkg::addr_width(MEM_WORDS);

  logic              imem_req;
  logic [AddrW-1:0]  imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;

  // Fetch sequencer side.
  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  // Memory side.
  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks the PC through instruction memory, one outstanding
// read at a time, with stall, redirect (including redirect of an in-flight read) and
// out-of-range fault handling.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pc_update,
  input  logic [31:0]        pc_new,
  input  logic               stall,
  fetch_sequencer_if.master  imem,
  output logic [31:0]        pc,
  output logic [31:0]        instr,
  output logic               instr_valid,
  output logic               fault
);

  localparam int unsigned AddrW = addr_width(MEM_WORDS);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         instr_valid_q, instr_valid_d;
  logic         kill_q, kill_d;
  logic [31:0]  pend_pc_q, pend_pc_d;

  // Redirect targets are always word aligned; the low byte-offset bits are dropped.
  logic [31:0] redirect_pc;
  logic [1:0]  unused_pc_new_lo;
  assign redirect_pc      = {pc_new[31:2], 2'b00};
  assign unused_pc_new_lo = pc_new[1:0];

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: PC, fetched word, valid flag and pending-redirect bookkeeping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      instr_q       <= 32'h0;
      instr_valid_q <= 1'b0;
      kill_q        <= 1'b0;
      pend_pc_q     <= 32'h0;
    end else begin
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      kill_q        <= kill_d;
      pend_pc_q     <= pend_pc_d;
    end
  end

  // Next-state and datapath update; redirect beats stall and sequential increment.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    kill_d        = kill_q;
    pend_pc_d     = pend_pc_q;

    unique case (state_q)
      StIdle: begin
        if (pc_update) begin
          pc_d    = redirect_pc;
          state_d = fetch_or_fault(redirect_pc, MEM_WORDS);
        end else begin
          state_d = fetch_or_fault(pc_q, MEM_WORDS);
        end
      end

      StReq: begin
        if (imem.imem_ack) begin
          if (pc_update || kill_q) begin
            // Data belongs to a redirected-away PC: drop it and fetch the newest target.
            pc_d    = pc_update ? redirect_pc : pend_pc_q;
            kill_d  = 1'b0;
            state_d = fetch_or_fault(pc_update ? redirect_pc : pend_pc_q, MEM_WORDS);
          end else begin
            instr_d       = imem.imem_rdata;
            instr_valid_d = 1'b1;
            state_d       = StValid;
          end
        end else if (pc_update) begin
          // The read in flight cannot be withdrawn; remember where to go once it returns.
          pend_pc_d = redirect_pc;
          kill_d    = 1'b1;
        end
      end

      StValid: begin
        if (pc_update) begin
          pc_d          = redirect_pc;
          instr_valid_d = 1'b0;
          state_d       = fetch_or_fault(redirect_pc, MEM_WORDS);
        end else if (!stall) begin
          pc_d          = pc_q + PC_STEP;
          instr_valid_d = 1'b0;
          state_d       = fetch_or_fault(pc_q + PC_STEP, MEM_WORDS);
        end
      end

      StFault: begin
        if (pc_update) begin
          pc_d    = redirect_pc;
          state_d = fetch_or_fault(redirect_pc, MEM_WORDS);
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decoded from registered state; the request is held for the whole REQ state.
  always_comb begin
    imem.imem_req  = (state_q == StReq);
    imem.imem_addr = pc_q[AddrW+1:2];
    fault          = (state_q == StFault);
    pc             = pc_q;
    instr          = instr_q;
    instr_valid    = instr_valid_q;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: behavioural memory with programmable ack latency, and a
// scoreboard of expected (pc, instr) pairs popped whenever instr_valid rises.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  localparam int unsigned MemWords = 64;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_update;
  logic [31:0] pc_new;
  logic        stall;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        fault;

  fetch_sequencer_if #(.MEM_WORDS(MemWords)) imem_bus ();

  fetch_sequencer #(
    .RESET_PC  (32'h0000_0000),
    .MEM_WORDS (MemWords)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pc_update   (pc_update),
    .pc_new      (pc_new),
    .stall       (stall),
    .imem        (imem_bus),
    .pc          (pc),
    .instr       (instr),
    .instr_valid (instr_valid),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  // Memory model: ack once the request has waited lat cycles (0 = same cycle).
  logic [31:0] mem [MemWords];
  int unsigned lat = 0;
  int unsigned wait_cnt = 0;
  logic        ack_force = 1'b0;

  assign imem_bus.imem_ack   = ack_force | (imem_bus.imem_req & (wait_cnt == lat));
  assign imem_bus.imem_rdata = imem_bus.imem_ack ? mem[imem_bus.imem_addr] : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (imem_bus.imem_req && !imem_bus.imem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic valid_prev = 1'b0;

  task automatic expect_fetch(input logic [31:0] p);
    exp_t e;
    e.pc    = p;
    e.instr = mem[p[7:2]];
    exp_q.push_back(e);
  endtask

  // Advance to the next falling edge and retire a scoreboard entry on each new valid.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (instr_valid === 1'b1 && valid_prev !== 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected: got pc=%h instr=%h, required no output", pc, instr);
      end else begin
        e = exp_q.pop_front();
        if (pc !== e.pc || instr !== e.instr) begin
          miscompares++;
          $display("FAIL sb_fetch: got pc=%h instr=%h, required pc=%h instr=%h",
                   pc, instr, e.pc, e.instr);
        end
      end
    end
    valid_prev = instr_valid;
  endtask

  task automatic test_reset();
    reset = 1'b0; pc_update = 1'b0; pc_new = 32'h0; stall = 1'b0;
    tick(); tick();
    vectors++; if (pc !== 32'h0) begin miscompares++; $display("FAIL reset_pc: got %h, required 0", pc); end
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b, required 0", instr_valid); end
    vectors++; if (instr !== 32'h0) begin miscompares++; $display("FAIL reset_instr: got %h, required 0", instr); end
    vectors++; if (fault !== 1'b0) begin miscompares++; $display("FAIL reset_fault: got %b, required 0", fault); end
    vectors++; if (imem_bus.imem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b, required 0", imem_bus.imem_req); end
  endtask

  task automatic test_zero_latency();
    for (int i = 0; i < 8; i++) expect_fetch(32'(i * 4));
    reset = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      vectors++;
      if (instr_valid !== ((i % 2) == 0)) begin
        miscompares++; $display("FAIL seq_valid cycle %0d: got %b, required %b", i, instr_valid, (i % 2) == 0);
      end
      if ((i % 2) == 1) begin
        vectors++;
        if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 6'((i - 1) / 2)) begin
          miscompares++; $display("FAIL seq_req cycle %0d: got req=%b addr=%0d, required req=1 addr=%0d", i, imem_bus.imem_req, imem_bus.imem_addr, (i - 1) / 2);
        end
      end
    end
  endtask

  task automatic test_latency();
    int reqs = 0;
    lat = 3;
    expect_fetch(32'h20);
    for (int i = 0; i < 12; i++) begin
      tick();
      if (imem_bus.imem_ack === 1'b1) break;
      if (imem_bus.imem_req === 1'b1) begin
        reqs++;
        vectors++;
        if (imem_bus.imem_addr !== 6'd8) begin
          miscompares++; $display("FAIL lat_addr_stable: got %0d, required 8", imem_bus.imem_addr);
        end
      end
    end
    vectors++; if (reqs != 3) begin miscompares++; $display("FAIL lat_wait_cycles: got %0d, required 3", reqs); end
    tick();
    vectors++; if (instr_valid !== 1'b1 || pc !== 32'h20) begin miscompares++; $display("FAIL lat_valid: got valid=%b pc=%h, required valid=1 pc=20", instr_valid, pc); end
    lat = 0;
  endtask

  task automatic test_stall();
    pc_update = 1'b1; pc_new = 32'h8;
    expect_fetch(32'h8);
    tick();
    pc_update = 1'b0;
    tick();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (pc !== 32'h8 || instr !== mem[2] || instr_valid !== 1'b1) begin
        miscompares++; $display("FAIL stall_hold: got pc=%h instr=%h valid=%b, required pc=8 instr=%h valid=1", pc, instr, instr_valid, mem[2]);
      end
    end
    stall = 1'b0;
    expect_fetch(32'hC);
    tick();
    vectors++; if (pc !== 32'hC || instr_valid !== 1'b0) begin miscompares++; $display("FAIL stall_release: got pc=%h valid=%b, required pc=c valid=0", pc, instr_valid); end
    tick();
  endtask

  task automatic test_kill();
    lat = 1000;
    pc_update = 1'b1; pc_new = 32'h4;
    tick();
    pc_update = 1'b0;
    tick();
    pc_update = 1'b1; pc_new = 32'h3C;
    tick();
    pc_new = 32'h13;
    tick();
    pc_update = 1'b0;
    vectors++;
    if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 6'd1 || pc !== 32'h4) begin
      miscompares++; $display("FAIL kill_hold: got req=%b addr=%0d pc=%h, required req=1 addr=1 pc=4", imem_bus.imem_req, imem_bus.imem_addr, pc);
    end
    expect_fetch(32'h10);
    ack_force = 1'b1;
    tick();
    ack_force = 1'b0;
    lat = 0;
    vectors++; if (pc !== 32'h10 || instr_valid !== 1'b0) begin miscompares++; $display("FAIL kill_discard: got pc=%h valid=%b, required pc=10 valid=0", pc, instr_valid); end
    tick();
    vectors++; if (instr_valid !== 1'b1 || instr !== mem[4]) begin miscompares++; $display("FAIL kill_refetch: got valid=%b instr=%h, required valid=1 instr=%h", instr_valid, instr, mem[4]); end
  endtask

  task automatic test_redirect_on_ack();
    expect_fetch(32'h20);
    tick();
    vectors++; if (pc !== 32'h14 || imem_bus.imem_ack !== 1'b1) begin miscompares++; $display("FAIL roa_setup: got pc=%h ack=%b, required pc=14 ack=1", pc, imem_bus.imem_ack); end
    pc_update = 1'b1; pc_new = 32'h20;
    tick();
    pc_update = 1'b0;
    vectors++; if (pc !== 32'h20 || instr_valid !== 1'b0) begin miscompares++; $display("FAIL roa_discard: got pc=%h valid=%b, required pc=20 valid=0", pc, instr_valid); end
    tick();
  endtask

  task automatic test_fault();
    pc_update = 1'b1; pc_new = 32'hFE;
    expect_fetch(32'hFC);
    tick();
    pc_update = 1'b0;
    vectors++; if (pc !== 32'hFC) begin miscompares++; $display("FAIL fault_align: got pc=%h, required fc", pc); end
    tick();
    tick();
    vectors++; if (fault !== 1'b1 || imem_bus.imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h100) begin
      miscompares++; $display("FAIL fault_wrap: got fault=%b req=%b valid=%b pc=%h, required 1 0 0 100", fault, imem_bus.imem_req, instr_valid, pc);
    end
    tick();
    vectors++; if (fault !== 1'b1 || pc !== 32'h100) begin miscompares++; $display("FAIL fault_stay: got fault=%b pc=%h, required fault=1 pc=100", fault, pc); end
    pc_update = 1'b1; pc_new = 32'h0;
    expect_fetch(32'h0);
    tick();
    pc_update = 1'b0;
    vectors++; if (fault !== 1'b0 || imem_bus.imem_req !== 1'b1) begin miscompares++; $display("FAIL fault_exit1: got fault=%b req=%b, required 0 1", fault, imem_bus.imem_req); end
    tick();
    pc_update = 1'b1; pc_new = 32'h100;
    tick();
    vectors++; if (fault !== 1'b1 || imem_bus.imem_req !== 1'b0) begin miscompares++; $display("FAIL fault_redirect: got fault=%b req=%b, required 1 0", fault, imem_bus.imem_req); end
    pc_new = 32'h0;
    expect_fetch(32'h0);
    tick();
    pc_update = 1'b0;
    vectors++; if (fault !== 1'b0 || pc !== 32'h0) begin miscompares++; $display("FAIL fault_exit2: got fault=%b pc=%h, required 0 0", fault, pc); end
    tick();
  endtask

  task automatic test_reset_mid_fetch();
    lat = 1000;
    tick();
    vectors++; if (imem_bus.imem_req !== 1'b1 || pc !== 32'h4) begin miscompares++; $display("FAIL rst_setup: got req=%b pc=%h, required req=1 pc=4", imem_bus.imem_req, pc); end
    reset = 1'b0;
    tick();
    vectors++; if (pc !== 32'h0 || instr_valid !== 1'b0 || imem_bus.imem_req !== 1'b0) begin
      miscompares++; $display("FAIL rst_abandon: got pc=%h valid=%b req=%b, required 0 0 0", pc, instr_valid, imem_bus.imem_req);
    end
    ack_force = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    vectors++; if (instr_valid !== 1'b0 || instr !== 32'h0 || imem_bus.imem_req !== 1'b1) begin
      miscompares++; $display("FAIL rst_late_ack: got valid=%b instr=%h req=%b, required 0 0 1", instr_valid, instr, imem_bus.imem_req);
    end
    ack_force = 1'b0;
    lat = 0;
    expect_fetch(32'h0);
    tick();
    vectors++; if (instr_valid !== 1'b1) begin miscompares++; $display("FAIL rst_restart: got valid=%b, required 1", instr_valid); end
  endtask

  initial begin
    logic [31:0] a = 32'd1;
    logic [31:0] b = 32'd1;
    logic [31:0] t;
    for (int i = 0; i < int'(MemWords); i++) begin
      mem[i] = {8'(i) ^ 8'hA0, a[23:0]};
      t = a + b; a = b; b = t;
    end
    test_reset();
    test_zero_latency();
    test_latency();
    test_stall();
    test_kill();
    test_redirect_on_ack();
    test_fault();
    test_reset_mid_fetch();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++; $display("FAIL sb_drain: got %0d pending entries, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h00000000, meaning the PC value loaded on reset.
REQ-002 The block SHALL have parameter MEM_WORDS, default 64, meaning the number of instruction memory words; legal PCs are 0 to 4*MEM_WORDS-4.
REQ-003 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-004 The block SHALL have port reset, input, 1; reset is synchronous and active-low.
REQ-005 The block SHALL have port pc_update, input, 1, a redirect request.
REQ-006 The block SHALL have port pc_new, input, 32, the redirect target PC.
REQ-007 The block SHALL have port stall, input, 1, which holds the current instruction.
REQ-008 The block SHALL have port imem_req, output, 1, the memory read request.
REQ-009 The block SHALL have port imem_addr, output, $clog2(MEM_WORDS), the word address, equal to pc>>2.
REQ-010 The block SHALL have port imem_ack, input, 1, meaning imem_rdata is valid this cycle.
REQ-011 The block SHALL have port imem_rdata, input, 32, the fetched word.
REQ-012 The block SHALL have port pc, output, 32, the PC of the current or pending fetch.
REQ-013 The block SHALL have port instr, output, 32, the fetched instruction.
REQ-014 The block SHALL have port instr_valid, output, 1, meaning instr and pc are a matched pair.
REQ-015 The block SHALL have port fault, output, 1, meaning the PC is out of range.

Function
REQ-016 The FSM SHALL have the states IDLE, REQ, VALID and FAULT.
REQ-017 From IDLE, the FSM SHALL enter REQ one cycle after reset is released, or enter FAULT if pc is out of range.
REQ-018 In REQ, imem_req SHALL be 1 and SHALL be held with a stable imem_addr until imem_ack is 1.
REQ-019 Memory latency SHALL be accepted from 0 to any number of cycles; an ack in the same cycle as the request completes the fetch.
REQ-020 On ack in REQ with no kill pending, imem_rdata SHALL be registered into instr, instr_valid SHALL rise the next cycle, and the FSM SHALL enter VALID.
REQ-021 In VALID with stall=1, pc, instr and instr_valid SHALL hold unchanged.
REQ-022 In VALID with stall=0, pc SHALL become pc+4 (modulo 2^32), instr_valid SHALL fall, and the FSM SHALL enter REQ, or FAULT if the new pc is out of range.
REQ-023 pc_update SHALL have priority over stall and over sequential increment.
REQ-024 The applied redirect target SHALL be {pc_new[31:2],2'b00}.
REQ-025 pc_update in IDLE, VALID or FAULT SHALL load pc next cycle, drop instr_valid, and enter REQ, or FAULT if the target is out of range.
REQ-026 pc_update in REQ before the ack SHALL store the target in a pending-redirect register and set kill.
  - imem_req and imem_addr stay unchanged until the ack.
  - The acked data is discarded: instr_valid stays 0.
  - pc then loads the pending target and the FSM re-enters REQ.
REQ-027 A later pc_update while kill is pending SHALL overwrite the pending target (last redirect wins).
REQ-028 pc_update in the same cycle as imem_ack in REQ SHALL discard that data and apply the new target next cycle.
REQ-029 In FAULT, fault SHALL be 1 and imem_req and instr_valid SHALL be 0; only an in-range pc_update or reset leaves FAULT.
REQ-030 pc SHALL change only on an increment, on a redirect application, or on reset.

Reset
REQ-031 While reset=0 at a clock edge, the next state SHALL be: state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, fault=0, kill=0, pending target=0.
REQ-032 Reset asserted mid-fetch SHALL abandon the fetch; an imem_ack arriving during or after reset while in IDLE SHALL be ignored.
REQ-033 reset SHALL override pc_update.

Structure
REQ-034 Package fetch_pkg SHALL hold the state enum, the PC_STEP=4 constant, and the width derivation for the word address.
REQ-035 The block SHALL be a single module with no sub-module; the memory and its latency model SHALL be testbench-side.

Verification
REQ-036 Scenario: reset, 0-latency memory loaded from fib20.mem -> pc steps 0,4,8,... with instr_valid=1 every second cycle and instr equal to mem[pc>>2].
REQ-037 Scenario: 3-cycle ack latency -> imem_req held for 3 cycles with imem_addr stable, then instr_valid=1.
REQ-038 Scenario: stall=1 for 4 cycles in VALID at pc=8 -> pc=8 and instr unchanged; after release, the next fetch is at pc=12.
REQ-039 Scenario: pc_update with pc_new=32'h13 during a pending fetch at pc=4 -> pc=4 data discarded, then a fetch at pc=32'h10 with instr_valid for it.
REQ-040 Scenario: pc_new=32'h100 with MEM_WORDS=64 -> fault=1 and imem_req=0; then pc_new=0 -> fault=0 and fetching restarts at 0.
REQ-041 Scenario: reset=0 asserted while imem_req=1 -> next cycle pc=RESET_PC, instr_valid=0, and a late ack is ignored.
